// File: rtl/hex_segment_bank_if.sv
// Switch/key side and display side of the hex segment bank.
// The board-facing driver owns the master modport; the bank owns the slave modport.
interface hex_segment_bank_if #(
   parameter int NUM_DISP = 6,
   parameter int SEG_W    = 7,
   parameter int SEL_W    = 3
);
   logic                      wr_key_n;
   logic                      clr_key_n;
   logic                      mode;
   logic [SEL_W-1:0]          sel;
   logic [SEG_W-1:0]          seg_in;
   logic [NUM_DISP*SEG_W-1:0] hex_out;
   logic [NUM_DISP-1:0]       blink_mask;
   logic                      wr_ack;
   logic                      sel_err;

   modport master (
      output wr_key_n, clr_key_n, mode, sel, seg_in,
      input  hex_out, blink_mask, wr_ack, sel_err
   );

   modport slave (
      input  wr_key_n, clr_key_n, mode, sel, seg_in,
      output hex_out, blink_mask, wr_ack, sel_err
   );
endinterface

// File: rtl/hex_segment_bank.sv
// Bank of registered segment displays loaded by debounced key presses,
// with per-display blink, clear-all, select-range error and write acknowledge.
module hex_segment_bank #(
   parameter int               NUM_DISP     = 6,
   parameter int               SEG_W        = 7,
   parameter int               SEL_W        = 3,
   parameter int               DEBOUNCE_CYC = 16,
   parameter int               BLINK_DIV    = 25000000,
   parameter logic [SEG_W-1:0] BLANK        = SEG_W'(7'h7F)
) (
   input logic               CLOCK_50,
   input logic               RESET,
   hex_segment_bank_if.slave bus
);
   localparam int              CNT_W    = $clog2(DEBOUNCE_CYC + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);
   localparam int              PH_W     = $clog2(BLINK_DIV);
   localparam logic [PH_W-1:0] PH_LAST  = PH_W'(BLINK_DIV - 1);

   logic [1:0]          key_raw;
   logic [1:0]          press_evt;
   logic                wr_evt;
   logic                clr_evt;
   logic                sel_ok;
   logic                ack_stage_reg;
   logic                err_stage_reg;
   logic                wr_ack_reg;
   logic                sel_err_reg;
   logic [PH_W-1:0]     ph_cnt_reg;
   logic                phase_reg;
   logic [NUM_DISP-1:0] mask_vec;

   // Index 0 is the write key, index 1 the clear key; both paths are identical.
   assign key_raw = {bus.clr_key_n, bus.wr_key_n};

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_key
         logic             sync1_reg;
         logic             sync2_reg;
         logic             level_reg;
         logic [CNT_W-1:0] cnt_reg;
         logic             differs;

         assign differs = (sync2_reg != level_reg);

         always_ff @(posedge CLOCK_50 or posedge RESET) begin
            if (RESET) begin
               sync1_reg <= 1'b1;
               sync2_reg <= 1'b1;
            end else begin
               sync1_reg <= key_raw[gi];
               sync2_reg <= sync1_reg;
            end
         end

         always_ff @(posedge CLOCK_50 or posedge RESET) begin
            if (RESET) begin
               level_reg <= 1'b1;
               cnt_reg   <= '0;
            end else if (!differs) begin
               cnt_reg <= '0;
            end else if (cnt_reg == CNT_LAST) begin
               level_reg <= sync2_reg;
               cnt_reg   <= '0;
            end else begin
               cnt_reg <= cnt_reg + 1'b1;
            end
         end

         // Fires on the same cycle the debounced level falls, so the action lands with the flip.
         assign press_evt[gi] = differs && level_reg && (cnt_reg == CNT_LAST);
      end
   endgenerate

   assign clr_evt = press_evt[1];
   assign wr_evt  = press_evt[0] && !press_evt[1];
   assign sel_ok  = ({1'b0, bus.sel} < (SEL_W + 1)'(NUM_DISP));

   always_ff @(posedge CLOCK_50 or posedge RESET) begin
      if (RESET) begin
         ack_stage_reg <= 1'b0;
         err_stage_reg <= 1'b0;
         wr_ack_reg    <= 1'b0;
         sel_err_reg   <= 1'b0;
      end else begin
         ack_stage_reg <= wr_evt && sel_ok;
         err_stage_reg <= wr_evt && !sel_ok;
         wr_ack_reg    <= ack_stage_reg;
         sel_err_reg   <= err_stage_reg;
      end
   end

   always_ff @(posedge CLOCK_50 or posedge RESET) begin
      if (RESET) begin
         ph_cnt_reg <= '0;
         phase_reg  <= 1'b0;
      end else if (ph_cnt_reg == PH_LAST) begin
         ph_cnt_reg <= '0;
         phase_reg  <= ~phase_reg;
      end else begin
         ph_cnt_reg <= ph_cnt_reg + 1'b1;
      end
   end

   generate
      for (gi = 0; gi < NUM_DISP; gi++) begin : g_disp
         logic [SEG_W-1:0] data_reg;
         logic             blink_reg;
         logic [SEG_W-1:0] hex_reg;
         logic             hit;

         assign hit = wr_evt && (bus.sel == SEL_W'(gi));

         always_ff @(posedge CLOCK_50 or posedge RESET) begin
            if (RESET) begin
               data_reg  <= BLANK;
               blink_reg <= 1'b0;
            end else if (clr_evt) begin
               data_reg  <= BLANK;
               blink_reg <= 1'b0;
            end else if (hit) begin
               if (bus.mode) begin
                  blink_reg <= ~blink_reg;
               end else begin
                  data_reg <= bus.seg_in;
               end
            end
         end

         // Blinking only masks the output stage; the stored pattern is untouched.
         always_ff @(posedge CLOCK_50 or posedge RESET) begin
            if (RESET) begin
               hex_reg <= BLANK;
            end else begin
               hex_reg <= (blink_reg && phase_reg) ? BLANK : data_reg;
            end
         end

         assign bus.hex_out[gi*SEG_W +: SEG_W] = hex_reg;
         assign mask_vec[gi]                  = blink_reg;
      end
   endgenerate

   assign bus.blink_mask = mask_vec;
   assign bus.wr_ack     = wr_ack_reg;
   assign bus.sel_err    = sel_err_reg;
endmodule

// File: tb/tb_hex_segment_bank.sv
// Scoreboard bench for hex_segment_bank: each key press pushes its expected
// outcome, which is popped and compared on the cycle the DUT should respond.
module tb_hex_segment_bank;
   localparam int         ND = 6;
   localparam int         SW = 7;
   localparam int         SLW = 3;
   localparam int         DC = 4;
   localparam int         BD = 4;
   localparam logic [6:0] BL = 7'h7F;

   typedef struct {
      logic        ack;
      logic        err;
      logic [41:0] data;
      logic [5:0]  mask;
   } exp_t;

   logic CLOCK_50 = 1'b0;
   logic RESET    = 1'b1;

   hex_segment_bank_if #(.NUM_DISP(ND), .SEG_W(SW), .SEL_W(SLW)) bus ();

   hex_segment_bank #(
      .NUM_DISP(ND), .SEG_W(SW), .SEL_W(SLW),
      .DEBOUNCE_CYC(DC), .BLINK_DIV(BD), .BLANK(BL)
   ) dut (
      .CLOCK_50(CLOCK_50),
      .RESET(RESET),
      .bus(bus)
   );

   always #10 CLOCK_50 = ~CLOCK_50;

   int          checks = 0;
   int          failures = 0;
   int          ack_count = 0;
   int          err_count = 0;
   exp_t        sb[$];
   logic [41:0] e_data;
   logic [5:0]  e_mask;

   // Reference blink phase; m_ph_prev is the phase the output stage used at the last edge.
   int unsigned m_cnt;
   bit          m_ph;
   bit          m_ph_prev;

   always @(posedge CLOCK_50 or posedge RESET) begin
      if (RESET) begin
         m_cnt     <= 0;
         m_ph      <= 1'b0;
         m_ph_prev <= 1'b0;
      end else begin
         m_ph_prev <= m_ph;
         if (m_cnt == BD - 1) begin
            m_cnt <= 0;
            m_ph  <= ~m_ph;
         end else begin
            m_cnt <= m_cnt + 1;
         end
      end
   end

   always @(negedge CLOCK_50) begin
      if (bus.wr_ack === 1'b1) ack_count++;
      if (bus.sel_err === 1'b1) err_count++;
   end

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [41:0] exp_hex(input logic [41:0] d, input logic [5:0] m, input bit ph);
      logic [41:0] r;
      for (int i = 0; i < ND; i++) begin
         r[i*SW +: SW] = (m[i] && ph) ? BL : d[i*SW +: SW];
      end
      return r;
   endfunction

   task automatic apply_model(input bit wr, input bit clr, input bit m, input logic [2:0] s,
                              input logic [6:0] d, output exp_t e);
      int si;
      si    = int'(s);
      e.ack = 1'b0;
      e.err = 1'b0;
      if (clr) begin
         e_data = {ND{BL}};
         e_mask = '0;
      end else if (wr) begin
         if (si >= ND) begin
            e.err = 1'b1;
         end else begin
            if (m) e_mask[si] = ~e_mask[si];
            else   e_data[si*SW +: SW] = d;
            e.ack = 1'b1;
         end
      end
      e.data = e_data;
      e.mask = e_mask;
   endtask

   task automatic expect_result(input string tag);
      exp_t e;
      if (sb.size() == 0) begin
         check_eq({tag, "_sb_empty"}, 64'd1, 64'd0);
      end else begin
         e = sb.pop_front();
         check_eq({tag, "_ack"}, 64'(bus.wr_ack), 64'(e.ack));
         check_eq({tag, "_err"}, 64'(bus.sel_err), 64'(e.err));
         check_eq({tag, "_mask"}, 64'(bus.blink_mask), 64'(e.mask));
         check_eq({tag, "_hex"}, 64'(bus.hex_out), 64'(exp_hex(e.data, e.mask, m_ph_prev)));
      end
   endtask

   task automatic press(input bit wr, input bit clr, input bit m, input logic [2:0] s,
                        input logic [6:0] d, input int hold, input string tag);
      exp_t e;
      int   a0;
      int   r0;
      apply_model(wr, clr, m, s, d, e);
      sb.push_back(e);
      a0 = ack_count;
      r0 = err_count;
      @(negedge CLOCK_50);
      bus.mode   = m;
      bus.sel    = s;
      bus.seg_in = d;
      if (wr)  bus.wr_key_n = 1'b0;
      if (clr) bus.clr_key_n = 1'b0;
      repeat (DC + 2) @(posedge CLOCK_50);
      #1 check_eq({tag, "_early"}, 64'({bus.wr_ack, bus.sel_err}), 64'd0);
      @(posedge CLOCK_50);
      #1 expect_result(tag);
      repeat (hold) @(posedge CLOCK_50);
      @(negedge CLOCK_50);
      bus.wr_key_n  = 1'b1;
      bus.clr_key_n = 1'b1;
      repeat (DC + 4) @(posedge CLOCK_50);
      @(negedge CLOCK_50);
      check_eq({tag, "_ack_cnt"}, 64'(ack_count - a0), 64'(e.ack));
      check_eq({tag, "_err_cnt"}, 64'(err_count - r0), 64'(e.err));
      $display("press %s wr=%0d clr=%0d mode=%0d sel=%0d seg=%02h", tag, wr, clr, m, s, d);
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [6:0] pats [ND];
      exp_t       e;
      int         a0;
      int         blanks;
      int         waited;

      pats = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12};
      bus.wr_key_n  = 1'b1;
      bus.clr_key_n = 1'b1;
      bus.mode      = 1'b0;
      bus.sel       = '0;
      bus.seg_in    = '0;
      e_data        = {ND{BL}};
      e_mask        = '0;

      // Reset state
      repeat (3) @(negedge CLOCK_50);
      check_eq("rst_hex", 64'(bus.hex_out), 64'({ND{BL}}));
      check_eq("rst_mask", 64'(bus.blink_mask), 64'd0);
      check_eq("rst_pulses", 64'({bus.wr_ack, bus.sel_err}), 64'd0);
      RESET = 1'b0;

      // 1: held write, exact latency, single ack over 100 cycles
      press(1'b1, 1'b0, 1'b0, 3'd3, 7'h40, 100, "t1_load3");

      // 2: bouncing key never settles long enough
      a0 = ack_count;
      for (int k = 0; k < 5; k++) begin
         @(negedge CLOCK_50) bus.wr_key_n = 1'b0;
         repeat (DC - 2) @(posedge CLOCK_50);
         @(negedge CLOCK_50) bus.wr_key_n = 1'b1;
         @(posedge CLOCK_50);
      end
      repeat (DC + 4) @(posedge CLOCK_50);
      #1;
      check_eq("t2_bounce_ack", 64'(ack_count - a0), 64'd0);
      check_eq("t2_bounce_hex", 64'(bus.hex_out), 64'(exp_hex(e_data, e_mask, m_ph_prev)));
      $display("bounce x5 done acks=%0d", ack_count - a0);
      press(1'b1, 1'b0, 1'b0, 3'd1, 7'h06, 5, "t2_load1");

      // 3: out-of-range selects
      press(1'b1, 1'b0, 1'b0, 3'd6, 7'h00, 3, "t3_sel6");
      press(1'b1, 1'b0, 1'b0, 3'd7, 7'h00, 3, "t3_sel7");

      // 4: blink on display 0, then off
      press(1'b1, 1'b0, 1'b0, 3'd0, 7'h12, 2, "t4_load0");
      press(1'b1, 1'b0, 1'b1, 3'd0, 7'h00, 2, "t4_blink_on");
      blanks = 0;
      for (int k = 0; k < 16; k++) begin
         @(posedge CLOCK_50);
         #1;
         check_eq("t4_slice0", 64'(bus.hex_out[6:0]),
                  64'(m_ph_prev ? BL : 7'h12));
         if (bus.hex_out[6:0] == BL) blanks++;
      end
      check_eq("t4_blank_cycles", 64'(blanks), 64'd8);
      check_eq("t4_mask", 64'(bus.blink_mask), 64'b000001);
      $display("blink window 16 cycles blank=%0d", blanks);
      press(1'b1, 1'b0, 1'b1, 3'd0, 7'h00, 2, "t4_blink_off");
      for (int k = 0; k < 8; k++) begin
         @(posedge CLOCK_50);
         #1 check_eq("t4_steady0", 64'(bus.hex_out[6:0]), 64'(7'h12));
      end

      // 5: load all, blink 1 and 4, clear; then clear and write together
      for (int i = 0; i < ND; i++) begin
         press(1'b1, 1'b0, 1'b0, 3'(i), pats[i], 0, "t5_load");
      end
      press(1'b1, 1'b0, 1'b1, 3'd1, 7'h00, 0, "t5_blink1");
      press(1'b1, 1'b0, 1'b1, 3'd4, 7'h00, 0, "t5_blink4");
      press(1'b0, 1'b1, 1'b0, 3'd0, 7'h00, 2, "t5_clear");
      press(1'b1, 1'b0, 1'b0, 3'd2, 7'h5A, 0, "t5_load2");
      press(1'b1, 1'b1, 1'b0, 3'd2, 7'h00, 2, "t5_clr_and_wr");

      // 6: reset mid-debounce while blink phase is 1
      press(1'b1, 1'b0, 1'b0, 3'd0, 7'h12, 0, "t6_load0");
      press(1'b1, 1'b0, 1'b1, 3'd0, 7'h00, 0, "t6_blink0");
      press(1'b1, 1'b0, 1'b0, 3'd5, 7'h08, 0, "t6_load5");
      waited = 0;
      @(negedge CLOCK_50);
      while (!(m_cnt == 1 && m_ph == 1'b0) && waited < 20) begin
         @(negedge CLOCK_50);
         waited++;
      end
      check_eq("t6_phase_wait", 64'(waited < 20), 64'd1);
      bus.mode     = 1'b0;
      bus.sel      = 3'd2;
      bus.seg_in   = 7'h55;
      bus.wr_key_n = 1'b0;
      repeat (4) @(posedge CLOCK_50);
      @(negedge CLOCK_50) RESET = 1'b1;
      #1;
      check_eq("t6_rst_hex", 64'(bus.hex_out), 64'({ND{BL}}));
      check_eq("t6_rst_mask", 64'(bus.blink_mask), 64'd0);
      check_eq("t6_rst_pulses", 64'({bus.wr_ack, bus.sel_err}), 64'd0);
      @(negedge CLOCK_50) RESET = 1'b0;
      e_data = {ND{BL}};
      e_mask = '0;
      a0     = ack_count;
      apply_model(1'b1, 1'b0, 1'b0, 3'd2, 7'h55, e);
      sb.push_back(e);
      repeat (DC + 2) @(posedge CLOCK_50);
      #1 check_eq("t6_early", 64'({bus.wr_ack, bus.sel_err}), 64'd0);
      @(posedge CLOCK_50);
      #1 expect_result("t6_after_rst");
      repeat (10) @(posedge CLOCK_50);
      @(negedge CLOCK_50) bus.wr_key_n = 1'b1;
      repeat (DC + 4) @(posedge CLOCK_50);
      @(negedge CLOCK_50);
      check_eq("t6_ack_cnt", 64'(ack_count - a0), 64'd1);
      $display("press t6_after_rst held through reset acks=%0d", ack_count - a0);

      check_eq("sb_drained", 64'(sb.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/hex_segment_bank.md
Name: hex_segment_bank

Overview:
- Parametrised successor to the switch-driven HEX selector: a bank of NUM_DISP registered segment displays written one at a time from a select/data input pair.
- Write and clear keys are synchronised, debounced and edge-detected, so one press produces exactly one action.
- Adds per-display blink, a clear-all key, out-of-range select detection and write acknowledge.
- Sits between board switches/keys and the HEX outputs in top-level demos.

Parameters:
- NUM_DISP, 6: number of displays, 1..8.
- SEG_W, 7: segment bits per display.
- SEL_W, 3: select width; must satisfy 2**SEL_W >= NUM_DISP.
- DEBOUNCE_CYC, 16: consecutive stable synchronised samples required to accept a key level change, >= 1.
- BLINK_DIV, 25000000: cycles per blink half-period, >= 2.
- BLANK, 7'h7F: segment pattern for an unlit display (active-low segments).

Ports:
- CLOCK_50, in, 1: sole clock, rising edge.
- RESET, in, 1: asynchronous, active-high reset.
- wr_key_n, in, 1: raw active-low write key, asynchronous to the clock.
- clr_key_n, in, 1: raw active-low clear-all key, asynchronous to the clock.
- mode, in, 1: write-press action select. 0 = load pattern; 1 = toggle blink bit.
- sel, in, SEL_W: target display index.
- seg_in, in, SEG_W: pattern to load.
- hex_out, out, NUM_DISP*SEG_W: display i occupies [i*SEG_W +: SEG_W].
- blink_mask, out, NUM_DISP: current blink enables.
- wr_ack, out, 1: one-cycle pulse when a write-press action is applied.
- sel_err, out, 1: one-cycle pulse when a write press targets sel >= NUM_DISP.

Behaviour:
- Reset (asynchronous, RESET=1):
  - all data registers = BLANK; blink_mask = 0; blink phase = 0; phase counter = 0.
  - synchroniser flops = 1; debounced key states = released; debounce counters = 0.
  - wr_ack = 0; sel_err = 0; hex_out = all BLANK.
- Key path, per key:
  - 2-flop synchroniser, then debounce counter.
  - Counter counts consecutive cycles where the synchronised level differs from the debounced state; it clears when the level matches.
  - When the counter reaches DEBOUNCE_CYC, the debounced state flips and the counter clears.
  - A press event is a one-cycle pulse on the released->pressed transition. Release produces no event.
  - A held key yields exactly one event. The next event requires a debounced release, then a new press.
- Latency: with a raw key held low from rising edge E0, the register change is visible on hex_out / blink_mask and the wr_ack / sel_err pulse is high after exactly DEBOUNCE_CYC+3 rising edges. The bench checks this value exactly.
- Write press, sel < NUM_DISP:
  - mode=0: data[sel] <= seg_in.
  - mode=1: blink_mask[sel] toggles.
  - wr_ack pulses 1 cycle.
  - sel, seg_in and mode are sampled on the event cycle only.
- Write press, sel >= NUM_DISP: no register changes; sel_err pulses 1 cycle; wr_ack stays 0.
- Clear press: all data <= BLANK; blink_mask <= 0. The blink phase counter is not affected. No ack pulse.
- Clear and write events in the same cycle: clear wins, write discarded, wr_ack = 0, sel_err = 0.
- Blink phase:
  - Free-running counter 0..BLINK_DIV-1. Phase toggles on the cycle the counter wraps to 0, so the period is 2*BLINK_DIV cycles.
  - hex_out slice i = BLANK when blink_mask[i]=1 and phase=1; otherwise data[i]. This is a registered output, one cycle behind the data/mask/phase registers, and is included in the stated latency.
- Toggling a blink bit off while phase=1 restores data[i] on the next output update; data[i] is never modified by blinking.
- RESET asserted mid-debounce or mid-blink: all state returns to reset values immediately. A key still held low after RESET deasserts produces one press event after the full debounce latency.
- Glitches shorter than DEBOUNCE_CYC cycles (post-synchroniser) produce no event.
- All arithmetic is unsigned. Counters are sized by $clog2 of their limits and never wrap past their limits.

Test Plan:
1. Reset, then hold wr_key_n low with mode=0, sel=3, seg_in=7'h40. Required: hex_out[27:21]=7'h40 and wr_ack high exactly DEBOUNCE_CYC+3 edges after first sample; other slices stay 7'h7F; key held for 100 cycles gives only one wr_ack.
2. Bounce wr_key_n low for DEBOUNCE_CYC-2 cycles, high 1 cycle, repeated 5 times. Required: no wr_ack; all slices remain BLANK. Then a stable press writes normally.
3. NUM_DISP=6, sel=6 then sel=7, press each time. Required: sel_err pulses once per press; wr_ack=0; hex_out unchanged.
4. BLINK_DIV=4: write 7'h12 to display 0, then press with mode=1, sel=0. Required: slice 0 alternates 7'h12 / 7'h7F every 4 cycles and blink_mask=6'b000001. A second mode=1 press clears the mask and slice 0 holds 7'h12.
5. Load displays 0..5 with distinct patterns and blink displays 1 and 4, then press clr_key_n. Required: all slices 7'h7F, blink_mask=0, no wr_ack. Then align clear and write presses to the same event cycle: clear wins, wr_ack=0.
6. Assert RESET for 1 cycle midway through a debounce count and during blink phase=1. Required: immediate BLANK outputs, blink_mask=0, pulses 0. A key held through reset yields exactly one wr_ack, DEBOUNCE_CYC+3 edges after RESET deasserts.
